muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the execute stage of the five-stage pipelined core.
- Replaces the single-cycle mul/div unit with one shift-add multiplier / restoring divider, sequenced by an FSM.
- Owns the HI/LO registers.
- Drives a stall request into the hazard unit whenever a mul/div-class instruction meets a busy unit.

Parameters:
WIDTH, 32, operand width and HI/LO width.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous active-high reset.
op_valid_i  input  1  execute stage holds a mul/div-class instruction.
funct_i  input  3  MulDivFunct code: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 reserved.
rs_value_i  input  WIDTH  forwarded rs operand (multiplicand / dividend).
rt_value_i  input  WIDTH  forwarded rt operand (multiplier / divisor).
stall_o  output  1  hold F, D and E stages this cycle.
result_o  output  WIDTH  MFHI/MFLO value for the execute write-back bus.
result_valid_o  output  1  result_o is valid.
hi_o  output  WIDTH  architectural HI.
lo_o  output  WIDTH  architectural LO.
busy_o  output  1  state is not IDLE.
div_zero_o  output  1  sticky flag: last accepted DIV/DIVU had rt = 0.

Behaviour:
- Reset: state IDLE, counter 0, hi_o = lo_o = 0, div_zero_o = 0. All outputs 0 while reset is high.
- A reset mid-operation abandons the operation; HI/LO return to 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - op_valid_i with funct 001–100 → capture operands at the edge (accept) and go to CALC, counter = 0.
  - Signed ops (001, 011) capture magnitudes and record the sign of the result and of the remainder.
  - stall_o stays 0 on the accept cycle; the instruction retires without writing a GPR.
- CALC:
  - One iteration per cycle: multiply is shift-add; divide is restoring subtract-shift.
  - After WIDTH iterations (counter = WIDTH-1 at the edge) go to FIX.
- FIX:
  - Apply the sign fix.
  - Signed quotient is negative iff operand signs differ; remainder takes the dividend's sign.
  - Product goes to {HI, LO}; for divide, remainder → HI and quotient → LO.
  - HI/LO update at the FIX edge; return to IDLE.
- Latency: an op accepted at edge n has HI/LO valid after edge n+WIDTH+1; busy_o is high between those edges.
- Divide by zero:
  - Takes the full normal latency.
  - Results: HI = dividend, LO = all ones.
  - div_zero_o is set at FIX and cleared when the next DIV/DIVU is accepted.
- Overflow case: signed 0x80000000 / -1 gives LO = 0x80000000, HI = 0 (wrap, no flag).
- MFHI/MFLO in IDLE: result_o = hi_o or lo_o combinationally, result_valid_o = 1, no stall.
- stall_o = op_valid_i & (funct in 001..110) & busy_o. This includes the FIX cycle, so an MFHI right after FIX sees the new value one cycle later.
- A second MULT/DIV arriving while busy is stalled, not queued; it is accepted on the first IDLE cycle.
- funct 000 and 111 are ignored: no stall, no state change, result_valid_o = 0.
- result_o = 0 whenever result_valid_o = 0.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: MULT/MULTU leave CALC early, after at least one iteration, once the remaining unconsumed multiplier bits are all zero. The partial product is aligned in FIX with the same FIX timing. Divide is unaffected.
- Undefined: every op takes exactly WIDTH CALC cycles.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_funct_e enum (codes above);
  - muldiv_state_e enum {IDLE, CALC, FIX};
  - constant MULDIV_FUNCT_W = 3.
- One sub-module, muldiv_iter_core: a single combinational iteration step (add/shift or trial-subtract/shift) taking the accumulator, operand, op type and iteration bit. The FSM, counter, HI/LO and sign fix stay in muldiv_sequencer.

Test Plan:
- Reset mid-op: MULTU 7, 6 accepted, then reset pulsed 5 cycles later → state IDLE, hi_o = lo_o = 0, busy_o = 0, no further updates.
- Unsigned multiply: MULTU 0xFFFFFFFF, 0xFFFFFFFF → after 33 edges hi_o = 0xFFFFFFFE, lo_o = 0x00000001; busy_o high for exactly 33 cycles.
- Signed divide: DIV -7, 2 → lo_o = 0xFFFFFFFD (-3), hi_o = 0xFFFFFFFF (-1); then DIV 0x80000000, -1 → lo_o = 0x80000000, hi_o = 0.
- Divide by zero: DIVU 25, 0 → hi_o = 25, lo_o = 0xFFFFFFFF, div_zero_o = 1; next DIVU 9, 3 → div_zero_o clears at accept, lo_o = 3, hi_o = 0.
- Hazard: MULT 3, -4 followed next cycle by MFLO held in execute → stall_o high until IDLE; then result_o = 0xFFFFFFF4 with result_valid_o = 1.
- Early out: with MULDIV_EARLY_OUT_EN, MULTU 5, 1 → busy for 2 cycles, lo_o = 5; without the macro → 33 cycles, same result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_FUNCT_W = 3;

  // MulDivFunct codes presented by the execute stage
  typedef enum logic [MULDIV_FUNCT_W-1:0] {
    F_NONE  = 3'd0,
    F_MULT  = 3'd1,
    F_MULTU = 3'd2,
    F_DIV   = 3'd3,
    F_DIVU  = 3'd4,
    F_MFHI  = 3'd5,
    F_MFLO  = 3'd6,
    F_RSVD  = 3'd7
  } muldiv_funct_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

  // Per-operation context captured at accept
  typedef struct packed {
    logic is_div;  // restoring divide rather than shift-add multiply
    logic neg_q;   // product / quotient must be negated in FIX
    logic neg_r;   // remainder must be negated in FIX
    logic dz;      // divisor was zero
  } muldiv_ctx_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Multiply: {hi,lo} holds partial product over the unconsumed multiplier bits.
// Divide:   hi is the running remainder, lo shifts dividend out / quotient in.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  input  logic             iter_bit,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Single iteration step, selected by operation type
  always_comb begin
    sum    = {1'b0, acc_hi} + (iter_bit ? {1'b0, operand} : '0);
    rem_sh = {acc_hi, iter_bit};
    ge     = rem_sh >= {1'b0, operand};
    // Only used when ge, where the true difference fits in WIDTH bits
    diff   = rem_sh[WIDTH-1:0] - operand;
    if (is_div) begin
      next_hi = ge ? diff : rem_sh[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative mul/div controller for the execute stage; owns HI/LO and raises
// the hazard stall. Optional macro MULDIV_EARLY_OUT_EN lets MULT/MULTU leave
// CALC once the remaining multiplier bits are all zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      op_valid_i,
  input  logic [MULDIV_FUNCT_W-1:0] funct_i,
  input  logic [WIDTH-1:0]          rs_value_i,
  input  logic [WIDTH-1:0]          rt_value_i,
  output logic                      stall_o,
  output logic [WIDTH-1:0]          result_o,
  output logic                      result_valid_o,
  output logic [WIDTH-1:0]          hi_o,
  output logic [WIDTH-1:0]          lo_o,
  output logic                      busy_o,
  output logic                      div_zero_o
);

  muldiv_state_e    state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] acc_hi, acc_hi_d, acc_lo, acc_lo_d;
  logic [WIDTH-1:0] operand, operand_d;
  muldiv_ctx_t      ctx, ctx_d;
  logic [WIDTH-1:0] hi, hi_d, lo, lo_d;
  logic             div_zero, div_zero_d;

  muldiv_funct_e    funct;
  logic             is_arith, is_mf, is_signed, op_div, busy, accept;
  logic             rs_neg, rt_neg, early_done;
  logic [WIDTH-1:0] rs_mag, rt_mag, next_hi, next_lo, quot, rem;
  logic [2*WIDTH-1:0] prod;

  assign funct     = muldiv_funct_e'(funct_i);
  assign is_arith  = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);
  assign is_mf     = (funct == F_MFHI) || (funct == F_MFLO);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign op_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign busy      = (state != IDLE);
  assign accept    = op_valid_i && is_arith && !busy;

  assign rs_neg = is_signed && rs_value_i[WIDTH-1];
  assign rt_neg = is_signed && rt_value_i[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_value_i : rs_value_i;
  assign rt_mag = rt_neg ? -rt_value_i : rt_value_i;

`ifdef MULDIV_EARLY_OUT_EN
  // Multiplier bits still to be consumed after this iteration are all zero
  assign early_done = !ctx.is_div &&
    (((acc_lo >> 1) & ({WIDTH{1'b1}} >> (cnt + CNT_W'(1)))) == '0);
`else
  assign early_done = 1'b0;
`endif

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .operand  (operand),
    .is_div   (ctx.is_div),
    .iter_bit (ctx.is_div ? acc_lo[WIDTH-1] : acc_lo[0]),
    .next_hi  (next_hi),
    .next_lo  (next_lo)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      ctx      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      acc_hi   <= acc_hi_d;
      acc_lo   <= acc_lo_d;
      operand  <= operand_d;
      ctx      <= ctx_d;
      hi       <= hi_d;
      lo       <= lo_d;
      div_zero <= div_zero_d;
    end
  end

  // Next-state, iteration and sign-fix logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    acc_hi_d   = acc_hi;
    acc_lo_d   = acc_lo;
    operand_d  = operand;
    ctx_d      = ctx;
    hi_d       = hi;
    lo_d       = lo;
    div_zero_d = div_zero;

    // After an early exit, cnt iterations were done; realign by the skipped ones
    prod = {acc_hi, acc_lo};
`ifdef MULDIV_EARLY_OUT_EN
    prod = prod >> (CNT_W'(WIDTH) - cnt);
`endif
    if (ctx.neg_q) prod = -prod;
    quot = ctx.neg_q ? -acc_lo : acc_lo;
    rem  = ctx.neg_r ? -acc_hi : acc_hi;

    case (state)
      IDLE: begin
        if (accept) begin
          ctx_d.is_div = op_div;
          ctx_d.neg_q  = rs_neg ^ rt_neg;
          ctx_d.neg_r  = rs_neg;
          ctx_d.dz     = op_div && (rt_value_i == '0);
          acc_hi_d     = '0;
          acc_lo_d     = op_div ? rs_mag : rt_mag;
          operand_d    = op_div ? rt_mag : rs_mag;
          cnt_d        = '0;
          state_d      = CALC;
          if (op_div) div_zero_d = 1'b0;
        end
      end
      CALC: begin
        acc_hi_d = next_hi;
        acc_lo_d = next_lo;
        cnt_d    = cnt + CNT_W'(1);
        if ((cnt == CNT_W'(WIDTH - 1)) || early_done) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (ctx.is_div) begin
          hi_d       = rem;
          lo_d       = ctx.dz ? '1 : quot;
          div_zero_d = ctx.dz;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hazard stall and MFHI/MFLO read port
  assign stall_o        = op_valid_i && (is_arith || is_mf) && busy;
  assign result_valid_o = !reset && op_valid_i && is_mf && !busy;
  assign result_o       = result_valid_o ? ((funct == F_MFHI) ? hi : lo) : '0;

  assign hi_o       = hi;
  assign lo_o       = lo;
  assign busy_o     = busy;
  assign div_zero_o = div_zero;

endmodule
